// File: rtl/alu_mc.sv
// Multi-cycle CGRA reconfigurable-cell ALU: single-cycle ALU ops plus a fixed-latency
// pipelined signed/fixed-point multiplier behind a valid/ready input handshake.

package cgra_pkg;
  localparam int unsigned CGRA_ALU_OP_WIDTH = 5;
  localparam int unsigned RCS_NUM_CREG_LOG2 = 6;

  localparam logic [CGRA_ALU_OP_WIDTH-1:0] CGRA_ALU_SADD   = 5'd0;
  localparam logic [CGRA_ALU_OP_WIDTH-1:0] CGRA_ALU_SSUB   = 5'd1;
  localparam logic [CGRA_ALU_OP_WIDTH-1:0] CGRA_ALU_SMUL   = 5'd2;
  localparam logic [CGRA_ALU_OP_WIDTH-1:0] CGRA_ALU_FXPMUL = 5'd3;
  localparam logic [CGRA_ALU_OP_WIDTH-1:0] CGRA_ALU_SLL    = 5'd4;
  localparam logic [CGRA_ALU_OP_WIDTH-1:0] CGRA_ALU_SRL    = 5'd5;
  localparam logic [CGRA_ALU_OP_WIDTH-1:0] CGRA_ALU_SRA    = 5'd6;
  localparam logic [CGRA_ALU_OP_WIDTH-1:0] CGRA_ALU_LAND   = 5'd7;
  localparam logic [CGRA_ALU_OP_WIDTH-1:0] CGRA_ALU_LOR    = 5'd8;
  localparam logic [CGRA_ALU_OP_WIDTH-1:0] CGRA_ALU_LXOR   = 5'd9;
  localparam logic [CGRA_ALU_OP_WIDTH-1:0] CGRA_ALU_LNAND  = 5'd10;
  localparam logic [CGRA_ALU_OP_WIDTH-1:0] CGRA_ALU_LNOR   = 5'd11;
  localparam logic [CGRA_ALU_OP_WIDTH-1:0] CGRA_ALU_LNXOR  = 5'd12;
  localparam logic [CGRA_ALU_OP_WIDTH-1:0] CGRA_ALU_BSFA   = 5'd13;
  localparam logic [CGRA_ALU_OP_WIDTH-1:0] CGRA_ALU_BZFA   = 5'd14;
  localparam logic [CGRA_ALU_OP_WIDTH-1:0] CGRA_ALU_BEQ    = 5'd15;
  localparam logic [CGRA_ALU_OP_WIDTH-1:0] CGRA_ALU_BNE    = 5'd16;
  localparam logic [CGRA_ALU_OP_WIDTH-1:0] CGRA_ALU_BLT    = 5'd17;
  localparam logic [CGRA_ALU_OP_WIDTH-1:0] CGRA_ALU_BGE    = 5'd18;
  localparam logic [CGRA_ALU_OP_WIDTH-1:0] CGRA_ALU_JUMP   = 5'd19;
endpackage

module alu_mc
  import cgra_pkg::*;
#(
  parameter int unsigned DP_WIDTH      = 32,
  parameter int unsigned FXP_FRAC_BITS = 15,
  parameter int unsigned MUL_LAT       = 2,
  parameter bit          FXP_SAT       = 1'b1,
  parameter int unsigned BR_ADD_W      = RCS_NUM_CREG_LOG2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [CGRA_ALU_OP_WIDTH-1:0] alu_op_i,
  input  logic [DP_WIDTH-1:0]          operand_a_i,
  input  logic [DP_WIDTH-1:0]          operand_b_i,
  input  logic [1:0]                   flag_i,
  input  logic                         fxp_round_i,
  input  logic                         flush_i,
  output logic                         out_valid_o,
  output logic [DP_WIDTH-1:0]          alu_res_o,
  output logic [1:0]                   flag_o,
  output logic                         br_req_o,
  output logic [BR_ADD_W-1:0]          br_add_o
);

  localparam int unsigned W     = DP_WIDTH;
  localparam int unsigned P_W   = 2 * DP_WIDTH;
  localparam int unsigned F     = FXP_FRAC_BITS;
  localparam int unsigned SH_W  = $clog2(DP_WIDTH);
  localparam int unsigned CNT_W = $clog2(MUL_LAT) + 1;

  typedef enum logic {S_IDLE, S_MBUSY} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept;
  logic               is_add, is_sub, is_shift, is_logic, is_cmp, is_smul, is_fxp, is_mul;
  logic [W-1:0]       add_a, add_b, sum;
  logic [W-1:0]       sh_a, sll_r, srl_r, sra_r;
  logic [SH_W-1:0]    sh_amt;
  logic [W-1:0]       lg_a, lg_b;
  logic [W-1:0]       cmp_a, cmp_b;
  logic               cmp_eq, cmp_lt;
  logic signed [P_W-1:0] mul_a_x, mul_b_x, prod, rnd_add, prod_r, p_sh;
  logic [W:0]         p_hi;
  logic               fxp_ovf;
  logic [W-1:0]       fxp_res, mul_res_c;
  logic [W-1:0]       sc_res;
  logic               sc_br;
  logic [BR_ADD_W-1:0] sc_badd;
  logic               mul_done;
  logic [W-1:0]       mul_done_res;
  logic               load_d, br_d;
  logic [W-1:0]       res_d;
  logic [BR_ADD_W-1:0] badd_d;

  assign in_ready_o = (state_q == S_IDLE) && !rst_i && !flush_i;
  assign accept     = in_valid_i && in_ready_o;

  // Op-class decode; qualified by accept so idle sub-units see zero inputs
  always_comb begin
    is_add   = 1'b0;
    is_sub   = 1'b0;
    is_shift = 1'b0;
    is_logic = 1'b0;
    is_cmp   = 1'b0;
    is_smul  = 1'b0;
    is_fxp   = 1'b0;
    if (accept) begin
      case (alu_op_i)
        CGRA_ALU_SADD, CGRA_ALU_JUMP:                 is_add   = 1'b1;
        CGRA_ALU_SSUB:                                is_sub   = 1'b1;
        CGRA_ALU_SLL, CGRA_ALU_SRL, CGRA_ALU_SRA:     is_shift = 1'b1;
        CGRA_ALU_LAND, CGRA_ALU_LOR, CGRA_ALU_LXOR,
        CGRA_ALU_LNAND, CGRA_ALU_LNOR, CGRA_ALU_LNXOR: is_logic = 1'b1;
        CGRA_ALU_BEQ, CGRA_ALU_BNE, CGRA_ALU_BLT,
        CGRA_ALU_BGE:                                 is_cmp   = 1'b1;
        CGRA_ALU_SMUL:                                is_smul  = 1'b1;
        CGRA_ALU_FXPMUL:                              is_fxp   = 1'b1;
        default: ;
      endcase
    end
  end

  assign is_mul = is_smul || is_fxp;

  // Adder (subtract as a + ~b + 1)
  assign add_a = (is_add || is_sub) ? operand_a_i : '0;
  assign add_b = is_add ? operand_b_i : (is_sub ? ~operand_b_i : '0);
  assign sum   = add_a + add_b + W'(is_sub);

  assign sh_a   = is_shift ? operand_a_i : '0;
  assign sh_amt = is_shift ? operand_b_i[SH_W-1:0] : '0;
  assign sll_r  = sh_a << sh_amt;
  assign srl_r  = sh_a >> sh_amt;
  assign sra_r  = $unsigned($signed(sh_a) >>> sh_amt);

  assign lg_a = is_logic ? operand_a_i : '0;
  assign lg_b = is_logic ? operand_b_i : '0;

  assign cmp_a  = is_cmp ? operand_a_i : '0;
  assign cmp_b  = is_cmp ? operand_b_i : '0;
  assign cmp_eq = (cmp_a == cmp_b);
  assign cmp_lt = ($signed(cmp_a) < $signed(cmp_b));

  // Signed 2W-bit product, optional round-half-up, then slice with saturation
  assign mul_a_x = is_mul ? {{W{operand_a_i[W-1]}}, operand_a_i} : '0;
  assign mul_b_x = is_mul ? {{W{operand_b_i[W-1]}}, operand_b_i} : '0;
  assign prod    = mul_a_x * mul_b_x;

  always_comb begin
    rnd_add = '0;
    if (is_fxp && fxp_round_i) rnd_add[F-1] = 1'b1;
  end

  assign prod_r  = prod + rnd_add;
  assign p_sh    = prod_r >>> F;
  assign p_hi    = p_sh[P_W-1:W-1];
  assign fxp_ovf = !((&p_hi) || !(|p_hi));

  always_comb begin
    fxp_res = p_sh[W-1:0];
    if (FXP_SAT && fxp_ovf) fxp_res = p_sh[P_W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end

  assign mul_res_c = is_smul ? prod[W-1:0] : fxp_res;

  // Single-cycle result selection
  always_comb begin
    sc_res  = '0;
    sc_br   = 1'b0;
    sc_badd = '0;
    case (alu_op_i)
      CGRA_ALU_SADD, CGRA_ALU_SSUB: sc_res = sum;
      CGRA_ALU_JUMP: begin
        sc_res  = sum;
        sc_br   = 1'b1;
        sc_badd = sum[BR_ADD_W-1:0];
      end
      CGRA_ALU_SLL:   sc_res = sll_r;
      CGRA_ALU_SRL:   sc_res = srl_r;
      CGRA_ALU_SRA:   sc_res = sra_r;
      CGRA_ALU_LAND:  sc_res = lg_a & lg_b;
      CGRA_ALU_LOR:   sc_res = lg_a | lg_b;
      CGRA_ALU_LXOR:  sc_res = lg_a ^ lg_b;
      CGRA_ALU_LNAND: sc_res = ~(lg_a & lg_b);
      CGRA_ALU_LNOR:  sc_res = ~(lg_a | lg_b);
      CGRA_ALU_LNXOR: sc_res = ~(lg_a ^ lg_b);
      CGRA_ALU_BSFA:  sc_res = flag_i[1] ? operand_a_i : operand_b_i;
      CGRA_ALU_BZFA:  sc_res = flag_i[0] ? operand_a_i : operand_b_i;
      CGRA_ALU_BEQ: begin sc_res = W'(cmp_eq);  sc_br = cmp_eq;  end
      CGRA_ALU_BNE: begin sc_res = W'(!cmp_eq); sc_br = !cmp_eq; end
      CGRA_ALU_BLT: begin sc_res = W'(cmp_lt);  sc_br = cmp_lt;  end
      CGRA_ALU_BGE: begin sc_res = W'(!cmp_lt); sc_br = !cmp_lt; end
      default: ;
    endcase
  end

  generate
    if (MUL_LAT == 1) begin : g_mul_comb
      assign mul_done     = is_mul;
      assign mul_done_res = mul_res_c;
    end else begin : g_mul_pipe
      localparam int unsigned DEPTH = MUL_LAT - 1;
      logic         v_q [DEPTH];
      logic [W-1:0] r_q [DEPTH];

      // Product delay line; flush and reset drop anything in flight
      always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
          for (int i = 0; i < int'(DEPTH); i++) begin
            v_q[i] <= 1'b0;
            r_q[i] <= '0;
          end
        end else begin
          v_q[0] <= is_mul;
          r_q[0] <= mul_res_c;
          for (int i = 1; i < int'(DEPTH); i++) begin
            v_q[i] <= v_q[i-1];
            r_q[i] <= r_q[i-1];
          end
        end
      end

      assign mul_done     = v_q[DEPTH-1];
      assign mul_done_res = r_q[DEPTH-1];
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (is_mul && (MUL_LAT > 1)) begin
          state_d = S_MBUSY;
          cnt_d   = CNT_W'(MUL_LAT - 1);
        end
      end
      S_MBUSY: begin
        if (cnt_q <= CNT_W'(1)) state_d = S_IDLE;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end

  // Multiply results and single-cycle accepts never collide: no accept while busy
  always_comb begin
    load_d = 1'b0;
    res_d  = sc_res;
    br_d   = sc_br;
    badd_d = sc_badd;
    if (mul_done) begin
      load_d = 1'b1;
      res_d  = mul_done_res;
      br_d   = 1'b0;
      badd_d = '0;
    end else if (accept && !is_mul) begin
      load_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      alu_res_o   <= '0;
      flag_o      <= 2'b01;
      br_req_o    <= 1'b0;
      br_add_o    <= '0;
    end else if (flush_i || !load_d) begin
      out_valid_o <= 1'b0;
      br_req_o    <= 1'b0;
      br_add_o    <= '0;
    end else begin
      out_valid_o <= 1'b1;
      alu_res_o   <= res_d;
      flag_o      <= {res_d[W-1], (res_d == '0)};
      br_req_o    <= br_d;
      br_add_o    <= badd_d;
    end
  end

endmodule
